// File: rtl/axi_ram_fifo_pkg.sv
// Shared definitions for the AXI RAM FIFO memory-sharing blocks:
// arbiter state encoding, port-index width helper and address-window checks.
package axi_ram_fifo_pkg;

  // Arbiter phases: IDLE arbitrates, ISSUE presents the command, WAIT holds
  // the grant until the memory side reports the burst complete.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Window helpers work on zero-extended values of this width, so any
  // MEM_ADDR_W up to 64 bits can share them.
  localparam int WIN_W = 64;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Address lies inside the window selected by base/mask.
  function automatic logic in_window(input logic [WIN_W-1:0] addr,
                                     input logic [WIN_W-1:0] base,
                                     input logic [WIN_W-1:0] mask);
    return (addr & ~mask) == base;
  endfunction

  // Last beat of the burst stays inside the window (no wrap past its end).
  // The sum is one bit wider so a carry out is never lost.
  function automatic logic fits_window(input logic [WIN_W-1:0] addr,
                                       input logic [WIN_W-1:0] len,
                                       input logic [WIN_W-1:0] mask);
    logic [WIN_W:0] end_off;
    end_off = {1'b0, addr & mask} + {1'b0, len};
    return end_off <= {1'b0, mask};
  endfunction

endpackage

// File: rtl/axi_ram_fifo_mem_arbiter_rr_select.sv
// Combinational round-robin priority encoder: starting at ptr and wrapping,
// picks the first set bit of elig. Shared by the memory-sharing blocks.
module rr_select #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  // Walk the candidates in ptr, ptr+1, ... order and keep the first hit.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    sum    = '0;
    pos    = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      pos = sum[IW-1:0];
      if (!any && elig[pos]) begin
        any         = 1'b1;
        idx         = pos;
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_ram_fifo_mem_arbiter.sv
// Round-robin owner of the single external memory command port. Each
// channel's burst is checked against its address window, issued one at a
// time, and the grant is held until mem_done or the watchdog expires.
//
// Handshakes: req_valid[k] is held by the channel until req_ready[k] pulses
// (request consumed, whether granted or rejected); mem_cmd_valid is held with
// stable fields until the cycle mem_cmd_ready is high, which is the transfer.
module axi_ram_fifo_mem_arbiter
  import axi_ram_fifo_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int MEM_ADDR_W = 30,
  parameter int LEN_W      = 8,
  parameter logic [NUM_PORTS*MEM_ADDR_W-1:0] FIFO_ADDR_BASE = {30'h02000000, 30'h00000000},
  parameter logic [NUM_PORTS*MEM_ADDR_W-1:0] FIFO_ADDR_MASK = {30'h01FFFFFF, 30'h01FFFFFF},
  parameter int TIMEOUT    = 4096
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              port_en,
  input  logic [NUM_PORTS-1:0]              req_valid,
  input  logic [NUM_PORTS-1:0]              req_write,
  input  logic [NUM_PORTS*MEM_ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*LEN_W-1:0]        req_len,
  output logic [NUM_PORTS-1:0]              req_ready,
  output logic [NUM_PORTS-1:0]              gnt,
  output logic                              mem_cmd_valid,
  input  logic                              mem_cmd_ready,
  output logic                              mem_cmd_write,
  output logic [MEM_ADDR_W-1:0]             mem_cmd_addr,
  output logic [LEN_W-1:0]                  mem_cmd_len,
  output logic [port_idx_w(NUM_PORTS)-1:0]  mem_cmd_port,
  input  logic                              mem_done,
  output logic [NUM_PORTS-1:0]              err_range,
  output logic [NUM_PORTS-1:0]              err_timeout,
  output logic                              busy
);

  localparam int PW   = port_idx_w(NUM_PORTS);
  localparam int WD_W = $clog2(TIMEOUT + 2);

  logic [1:0]            rst_sync;
  logic                  run;
  arb_state_e            state, state_nxt;
  logic [PW-1:0]         rr_ptr;
  logic [WD_W-1:0]       wd_cnt;
  logic                  wd_hit;
  logic                  to_fire;

  logic [NUM_PORTS-1:0]  elig;
  logic [NUM_PORTS-1:0]  sel_oh;
  logic [PW-1:0]         sel_idx;
  logic                  sel_any;
  logic [MEM_ADDR_W-1:0] sel_addr, sel_base, sel_mask;
  logic [LEN_W-1:0]      sel_len;
  logic                  sel_write;
  logic                  win_ok;
  logic                  accept_ok;

  // Reset release is re-timed to clk; assertion still clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run  = rst_sync[1];
  assign elig = (run && state == ST_IDLE) ? (req_valid & port_en) : '0;

  rr_select #(.N(NUM_PORTS), .IW(PW)) u_rr_select (
    .elig   (elig),
    .ptr    (rr_ptr),
    .onehot (sel_oh),
    .idx    (sel_idx),
    .any    (sel_any)
  );

  assign sel_addr  = req_addr[int'(sel_idx)*MEM_ADDR_W +: MEM_ADDR_W];
  assign sel_len   = req_len[int'(sel_idx)*LEN_W +: LEN_W];
  assign sel_write = req_write[sel_idx];
  assign sel_base  = FIFO_ADDR_BASE[int'(sel_idx)*MEM_ADDR_W +: MEM_ADDR_W];
  assign sel_mask  = FIFO_ADDR_MASK[int'(sel_idx)*MEM_ADDR_W +: MEM_ADDR_W];

  assign win_ok    = in_window(WIN_W'(sel_addr), WIN_W'(sel_base), WIN_W'(sel_mask)) &&
                     fits_window(WIN_W'(sel_addr), WIN_W'(sel_len), WIN_W'(sel_mask));
  assign accept_ok = sel_any && win_ok;

  // A selected request is always consumed; a window violation also flags it.
  assign req_ready = sel_oh;
  assign err_range = (sel_any && !win_ok) ? sel_oh : '0;

  // Watchdog counts cycles since acceptance; expiry on the TIMEOUT-th one.
  assign wd_hit = (TIMEOUT != 0) && ((int'(wd_cnt) + 1) >= TIMEOUT);

  // Next phase; completion or command transfer outranks a watchdog expiry.
  always_comb begin
    state_nxt = state;
    to_fire   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_ok) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (mem_cmd_ready) begin
          state_nxt = ST_WAIT;
        end else if (wd_hit) begin
          state_nxt = ST_IDLE;
          to_fire   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          state_nxt = ST_IDLE;
        end else if (wd_hit) begin
          state_nxt = ST_IDLE;
          to_fire   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Phase, round-robin pointer, watchdog and the latched command fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      wd_cnt        <= '0;
      mem_cmd_write <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_cmd_len   <= '0;
      mem_cmd_port  <= '0;
    end else begin
      state <= state_nxt;
      if (sel_any) begin
        rr_ptr <= (sel_idx == PW'(NUM_PORTS - 1)) ? '0 : sel_idx + 1'b1;
      end
      if (accept_ok) begin
        wd_cnt        <= '0;
        mem_cmd_write <= sel_write;
        mem_cmd_addr  <= sel_addr;
        mem_cmd_len   <= sel_len;
        mem_cmd_port  <= sel_idx;
      end else if (state != ST_IDLE && int'(wd_cnt) < TIMEOUT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  assign busy          = (state != ST_IDLE);
  assign mem_cmd_valid = (state == ST_ISSUE);
  assign gnt           = busy ? (NUM_PORTS'(1) << mem_cmd_port) : '0;
  assign err_timeout   = to_fire ? gnt : '0;

endmodule

// File: doc/axi_ram_fifo_mem_arbiter.md
Name: axi_ram_fifo_mem_arbiter

Overview:
- Round-robin scheduler that shares one external memory command port between the NUM_PORTS channels of the AXI RAM FIFO block.
- Each channel requests read or write bursts into its own address window. The arbiter checks each burst against that window, issues one burst at a time and holds the grant until the memory side signals completion.
- A watchdog releases a hung burst. Sits in the mem_clk domain, between the per-channel FIFO engines and the AXI memory master.

Parameters:
NUM_PORTS, 2, number of requesting channels (1..16)
MEM_ADDR_W, 30, word-address width (one word = one beat)
LEN_W, 8, burst length field width; value = beats-1
FIFO_ADDR_BASE, {30'h02000000,30'h00000000}, per-port window base, packed NUM_PORTS*MEM_ADDR_W
FIFO_ADDR_MASK, {30'h01FFFFFF,30'h01FFFFFF}, per-port window offset mask, same packing
TIMEOUT, 4096, cycles allowed from command issue to mem_done; 0 disables watchdog

Ports:
clk  in  1  memory-domain clock (mem_clk)
rst_n  in  1  asynchronous, active-low reset
port_en  in  NUM_PORTS  per-channel enable; disabled channels are never granted
req_valid  in  NUM_PORTS  burst request per channel
req_write  in  NUM_PORTS  1=write burst, 0=read burst
req_addr  in  NUM_PORTS*MEM_ADDR_W  burst start word address
req_len  in  NUM_PORTS*LEN_W  beats-1
req_ready  out  NUM_PORTS  one-cycle accept pulse (request consumed, granted or rejected)
gnt  out  NUM_PORTS  one-hot owner of memory port, held until burst ends
mem_cmd_valid  out  1  command valid to memory master
mem_cmd_ready  in  1  command accepted
mem_cmd_write  out  1  direction
mem_cmd_addr  out  MEM_ADDR_W  start address
mem_cmd_len  out  LEN_W  beats-1
mem_cmd_port  out  $clog2(NUM_PORTS) (min 1)  owning channel index
mem_done  in  1  one-cycle pulse: last read beat delivered or write response received
err_range  out  NUM_PORTS  one-cycle pulse, request rejected for window violation
err_timeout  out  NUM_PORTS  one-cycle pulse, watchdog expired on that port's burst
busy  out  1  high in ISSUE or WAIT

Behaviour:
- Reset: rst_n low drives all outputs, state, RR pointer and watchdog to 0 asynchronously. Deassertion is synchronised internally (2-flop) and takes effect on a clk edge. Reset mid-burst abandons the burst; no error pulse is generated.
- Eligibility: port k is eligible when req_valid[k] & port_en[k].
- RR pointer P (reset 0): search order is P, P+1, …, wrapping mod NUM_PORTS. After any acceptance of port k, P <= (k+1) mod NUM_PORTS.
- Window check (combinational, port k):
  - in-window: (addr & ~MASK_k) == BASE_k.
  - end = (addr & MASK_k) + len, computed MEM_ADDR_W+1 bits wide; must be <= MASK_k (no wrap past the window end).
- State IDLE, with an eligible port k selected:
  - pass: req_ready[k]=1 for one cycle. Register cmd fields and gnt[k]. Next state ISSUE, with mem_cmd_valid=1 starting the cycle after acceptance.
  - fail: req_ready[k]=1 and err_range[k]=1 for the same cycle. Stay in IDLE. Next arbitration is the following cycle.
- State ISSUE: mem_cmd_valid held with stable fields until mem_cmd_ready. The handshake cycle goes to WAIT and drops mem_cmd_valid next cycle. mem_done in ISSUE is ignored.
- State WAIT: mem_done goes to IDLE and clears gnt next cycle. The earliest next acceptance is the cycle after return to IDLE, so there is a minimum 1 idle cycle between bursts.
- Watchdog: counter cleared on acceptance; increments each cycle in ISSUE/WAIT.
  - When it reaches TIMEOUT: err_timeout[owner] pulse, mem_cmd_valid drops, go to IDLE.
  - mem_done or mem_cmd_ready on the expiry cycle takes priority; no error is raised in that case.
- port_en or req_valid deasserting mid-burst: no effect on the burst in flight.
- gnt is one-hot or zero at all times; busy == |gnt.

Decomposition:
- Shared package axi_ram_fifo_pkg holds: state encoding (IDLE/ISSUE/WAIT), the port-index width function, and window slice helpers.
- One sub-module: rr_select, a combinational round-robin priority encoder (eligible vector + pointer -> one-hot + index + any). It is reused by other sharing blocks.

Test Plan:
- Single request, port0 addr 0x10 len 3 -> req_ready[0] pulse at T. mem_cmd_valid at T+1 with addr 0x10, len 3, port 0. busy until the cycle after mem_done.
- Both ports held valid continuously, mem_cmd_ready=1, mem_done 2 cycles after each command -> grants alternate 0,1,0,1. No port is granted twice consecutively.
- Port1 addr 0x00000100, outside base 0x02000000 -> req_ready[1] and err_range[1] on the same cycle. No mem_cmd_valid. Port0 is served next cycle if pending.
- Port0 addr 0x01FFFFFE len 3, crossing the window end -> err_range[0]. Same addr with len 1 -> accepted.
- TIMEOUT=16, never assert mem_done -> err_timeout[owner] 16 cycles after acceptance, gnt clears. mem_done on exactly cycle 16 -> no error.
- rst_n pulsed low while in WAIT -> gnt, busy and mem_cmd_valid go 0 immediately. After release the first grant goes to port 0.
